// File: rtl/imul_int_mul_var_lat.sv
`default_nettype none
// ============================================================================
// imul_int_mul_var_lat : variable-latency shift-add multiplier (MUL/MULH/MULHSU/MULHU)
// Optional macro LAB2_IMUL_CYCLE_CNT_EN adds last_lat. Rev 1.0
// ============================================================================
module imul_int_mul_var_lat #(
    parameter int NBITS     = 32,
    parameter int MAX_SHAMT = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 istream_val,
    output logic                 istream_rdy,
    input  logic [2*NBITS+1:0]   istream_msg,
    output logic                 ostream_val,
    input  logic                 ostream_rdy,
    output logic [NBITS-1:0]     ostream_msg
`ifdef LAB2_IMUL_CYCLE_CNT_EN
    ,
    output logic [7:0]           last_lat
`endif
);

    localparam int c_SH_W = $clog2(MAX_SHAMT + 1);
    localparam logic [1:0] c_OP_MUL    = 2'd0;
    localparam logic [1:0] c_OP_MULH   = 2'd1;
    localparam logic [1:0] c_OP_MULHU  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_SIGN = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t               state_q;
    logic [1:0]           op_q;
    logic                 sign_q;
    logic [2*NBITS-1:0]   a_q;
    logic [NBITS-1:0]     b_q;
    logic [2*NBITS-1:0]   acc_q;

    logic [1:0]           w_op;
    logic [NBITS-1:0]     w_a;
    logic [NBITS-1:0]     w_b;
    logic                 w_a_neg;
    logic                 w_b_neg;
    logic [NBITS-1:0]     w_a_mag;
    logic [NBITS-1:0]     w_b_mag;
    logic                 w_accept;
    logic [c_SH_W-1:0]    w_tz;

    assign w_op    = istream_msg[2*NBITS+1:2*NBITS];
    assign w_a     = istream_msg[2*NBITS-1:NBITS];
    assign w_b     = istream_msg[NBITS-1:0];
    // a is signed for every op but MULHU; b only for MUL and MULH
    assign w_a_neg = (w_op != c_OP_MULHU) && w_a[NBITS-1];
    assign w_b_neg = ((w_op == c_OP_MUL) || (w_op == c_OP_MULH)) && w_b[NBITS-1];
    assign w_a_mag = w_a_neg ? (~w_a + 1'b1) : w_a;
    assign w_b_mag = w_b_neg ? (~w_b + 1'b1) : w_b;

    assign istream_rdy = (state_q == ST_IDLE) || ((state_q == ST_DONE) && ostream_rdy);
    assign w_accept    = istream_val && istream_rdy;
    assign ostream_val = (state_q == ST_DONE);
    assign ostream_msg = (state_q != ST_DONE) ? '0 :
                         (op_q == c_OP_MUL)   ? acc_q[NBITS-1:0] : acc_q[2*NBITS-1:NBITS];

    // Lowest set bit in the low MAX_SHAMT bits of B; MAX_SHAMT when none is set
    always_comb begin
        w_tz = c_SH_W'(MAX_SHAMT);
        for (int i = MAX_SHAMT - 1; i >= 0; i--) begin
            if (b_q[i]) w_tz = c_SH_W'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            sign_q  <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
        end else if (w_accept) begin
            state_q <= ST_CALC;
            op_q    <= w_op;
            sign_q  <= w_a_neg ^ w_b_neg;
            a_q     <= {{NBITS{1'b0}}, w_a_mag};
            b_q     <= w_b_mag;
            acc_q   <= '0;
        end else begin
            case (state_q)
                ST_CALC: begin
                    if (b_q == '0) begin
                        state_q <= ST_SIGN;
                    end else if (b_q[0]) begin
                        acc_q <= acc_q + a_q;
                        a_q   <= a_q << 1;
                        b_q   <= b_q >> 1;
                    end else begin
                        a_q <= a_q << w_tz;
                        b_q <= b_q >> w_tz;
                    end
                end
                ST_SIGN: begin
                    if (sign_q) acc_q <= ~acc_q + 1'b1;
                    state_q <= ST_DONE;
                end
                ST_DONE: begin
                    if (ostream_rdy) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef LAB2_IMUL_CYCLE_CNT_EN
    logic [7:0] cnt_q;
    logic [7:0] last_lat_q;
    logic [7:0] w_cnt_inc;

    assign w_cnt_inc = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
    assign last_lat  = last_lat_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q      <= '0;
            last_lat_q <= '0;
        end else begin
            if (w_accept) begin
                cnt_q <= '0;
            end else if ((state_q == ST_CALC) || (state_q == ST_SIGN)) begin
                cnt_q <= w_cnt_inc;
            end
            // The SIGN cycle itself counts, so capture the incremented value
            if (state_q == ST_SIGN) last_lat_q <= w_cnt_inc;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_imul_int_mul_var_lat.sv
`default_nettype none
// ============================================================================
// tb_imul_int_mul_var_lat : directed bench with a reference model of the multiplier
// Rev 1.0
// ============================================================================
module tb_imul_int_mul_var_lat;

    localparam int c_N = 32;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             istream_val = 1'b0;
    logic             istream_rdy;
    logic [2*c_N+1:0] istream_msg = '0;
    logic             ostream_val;
    logic             ostream_rdy = 1'b1;
    logic [c_N-1:0]   ostream_msg;
`ifdef LAB2_IMUL_CYCLE_CNT_EN
    logic [7:0]       last_lat;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    imul_int_mul_var_lat #(.NBITS(c_N), .MAX_SHAMT(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .istream_val (istream_val),
        .istream_rdy (istream_rdy),
        .istream_msg (istream_msg),
        .ostream_val (ostream_val),
        .ostream_rdy (ostream_rdy),
        .ostream_msg (ostream_msg)
`ifdef LAB2_IMUL_CYCLE_CNT_EN
        ,
        .last_lat    (last_lat)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: full-width product of the sign/zero-extended operands
    function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea, eb, p;
        ea = (op == 2'd3) ? {32'h0, a} : {{32{a[31]}}, a};
        eb = (op[1]) ? {32'h0, b} : {{32{b[31]}}, b};
        p  = ea * eb;
        return (op == 2'd0) ? p[31:0] : p[63:32];
    endfunction

    // Number of CALC cycles: one per add or zero-skip, plus the final zero check
    function automatic int ref_calc_cycles(input logic [1:0] op, input logic [31:0] b);
        logic [31:0] x;
        int n, s;
        x = (!op[1] && b[31]) ? (~b + 32'd1) : b;
        n = 1;
        while (x != 0) begin
            if (x[0]) begin
                x = x >> 1;
            end else begin
                s = 0;
                while (s < 8 && x[s] == 1'b0) s++;
                x = x >> s;
            end
            n++;
        end
        return n;
    endfunction

    typedef struct {
        logic [31:0] res;
        int          due;
    } exp_t;
    exp_t q[$];

    // Cycle-by-cycle comparison of every output against the model
    always @(negedge clk) begin
        logic        e_val, e_rdy;
        logic [31:0] e_msg;
        exp_t        e;
        if (cyc >= 1) begin
            e_val = (q.size() > 0) && (cyc >= q[0].due);
            e_msg = e_val ? q[0].res : 32'h0;
            e_rdy = (q.size() == 0) ? 1'b1 : (e_val ? ostream_rdy : 1'b0);
            check("mon_ostream_val", {63'h0, ostream_val}, {63'h0, e_val});
            check("mon_ostream_msg", {32'h0, ostream_msg}, {32'h0, e_msg});
            check("mon_istream_rdy", {63'h0, istream_rdy}, {63'h0, e_rdy});
            if (reset) begin
                q.delete();
            end else begin
                if (e_val && ostream_rdy) void'(q.pop_front());
                if (istream_val && e_rdy) begin
                    e.res = ref_result(istream_msg[65:64], istream_msg[63:32], istream_msg[31:0]);
                    e.due = cyc + ref_calc_cycles(istream_msg[65:64], istream_msg[31:0]) + 2;
                    q.push_back(e);
                end
            end
        end
    end

    task automatic wait_val(input int t0, output int lat);
        int n;
        n = 0;
        @(negedge clk);
        while (!ostream_val && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!ostream_val) check("timeout_ostream_val", 64'h0, 64'h1);
        lat = cyc - t0;
    endtask

    task automatic txn(input string name, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_msg, input int exp_lat);
        int t0, lat;
        @(posedge clk); #1;
        istream_val = 1'b1;
        istream_msg = {op, a, b};
        t0 = cyc;
        @(posedge clk); #1;
        istream_val = 1'b0;
        wait_val(t0, lat);
        check({name, "_msg"}, {32'h0, ostream_msg}, {32'h0, exp_msg});
        if (exp_lat > 0) check({name, "_lat"}, 64'(lat), 64'(exp_lat));
        @(posedge clk); #1;
    endtask

    initial begin
        int t0, lat;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset_istream_rdy", {63'h0, istream_rdy}, 64'h1);
        check("reset_ostream_val", {63'h0, ostream_val}, 64'h0);
        check("reset_ostream_msg", {32'h0, ostream_msg}, 64'h0);

        txn("mul_3x4", 2'd0, 32'd3, 32'd4, 32'h0000000C, 5);
`ifdef LAB2_IMUL_CYCLE_CNT_EN
        check("last_lat_b4", {56'h0, last_lat}, 64'd4);
`endif
        txn("mulh_m1xm1",  2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 4);
        txn("mulhu_ffxff", 2'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 35);
        txn("mulhsu_m1x2", 2'd2, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 0);
        txn("mulh_minxmin",2'd1, 32'h80000000, 32'h80000000, 32'h40000000, 0);
        txn("mul_1xmin",   2'd0, 32'd1,        32'h80000000, 32'h80000000, 8);
        txn("mul_b0",      2'd0, 32'h12345678, 32'd0,        32'h00000000, 3);
`ifdef LAB2_IMUL_CYCLE_CNT_EN
        check("last_lat_b0", {56'h0, last_lat}, 64'd2);
`endif
        txn("mul_neg",     2'd0, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFEB, 0);

        // Back-pressure, then consume and accept in the same cycle
        @(posedge clk); #1;
        ostream_rdy = 1'b0;
        istream_val = 1'b1;
        istream_msg = {2'd0, 32'd2, 32'd9};
        t0 = cyc;
        @(posedge clk); #1;
        istream_val = 1'b0;
        wait_val(t0, lat);
        for (int i = 0; i < 5; i++) begin
            check("hold_msg", {32'h0, ostream_msg}, 64'd18);
            check("hold_istream_rdy", {63'h0, istream_rdy}, 64'h0);
            @(negedge clk);
        end
        @(posedge clk); #1;
        ostream_rdy = 1'b1;
        istream_val = 1'b1;
        istream_msg = {2'd0, 32'd5, 32'd7};
        t0 = cyc;
        @(posedge clk); #1;
        istream_val = 1'b0;
        wait_val(t0, lat);
        check("b2b_msg", {32'h0, ostream_msg}, 64'h23);
        check("b2b_lat", 64'(lat), 64'd6);
        @(posedge clk); #1;

        // Reset in the middle of a long CALC
        istream_val = 1'b1;
        istream_msg = {2'd3, 32'hFFFFFFFF, 32'hFFFFFFFF};
        @(posedge clk); #1;
        istream_val = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("abort_ostream_val", {63'h0, ostream_val}, 64'h0);
        check("abort_istream_rdy", {63'h0, istream_rdy}, 64'h1);
        check("abort_ostream_msg", {32'h0, ostream_msg}, 64'h0);
        txn("after_reset_6x7", 2'd0, 32'd6, 32'd7, 32'h0000002A, 6);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
